// File: rtl/game_pkg.sv
// Shared definitions for the catch-the-ball game controller: state encoding,
// LFSR seed and the LFSR step function.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [9:0] LFSR_SEED = 10'h2A5;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    // x^10 + x^7 + 1, shift-left Fibonacci form; maximal length, so a
    // non-zero seed never reaches the all-zero lock-up state.
    function automatic logic [9:0] lfsr_next(input logic [9:0] q);
        return {q[8:0], q[9] ^ q[6]};
    endfunction

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit LFSR used to pick the ball spawn column.
module lfsr10
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: spawns a ball at a pseudo-random column, drops it one row
// per tick and scores a catch or a miss against the paddle at the floor row.
//
// state | meaning
// IDLE  | after reset, waiting for start
// SPAWN | one cycle: load new ball column, row 0
// PLAY  | ball falls one row per tick
// CHECK | one cycle: compare ball against paddle, pulse hit or miss
// OVER  | no lives left, ball and score frozen until start
module game_ctrl
    import game_pkg::*;
#(
    parameter int PADDLE_W    = 64,
    parameter int FLOOR_Y     = 440,
    parameter int START_LIVES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       tick,
    input  logic [9:0] x_paddle,
    output logic [9:0] x_ball,
    output logic [9:0] y_ball,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       run,
    output logic       hit,
    output logic       miss,
    output logic [2:0] state
);

    localparam logic [9:0]  FLOOR_ROW  = 10'(FLOOR_Y);
    localparam logic [1:0]  LIVES_INIT = 2'(START_LIVES);
    localparam logic [10:0] PAD_WIDTH  = 11'(PADDLE_W);

    state_t      st;
    logic [9:0]  lfsr_q;
    logic [9:0]  spawn_x;
    logic [9:0]  y_next;
    logic [1:0]  lives_dec;
    logic [10:0] ball_w;
    logic [10:0] pad_lo;
    logic [10:0] pad_hi;
    logic        caught;

    lfsr10 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Top bit cleared keeps the spawn column inside 0..511.
    assign spawn_x   = lfsr_q & 10'h1FF;
    assign y_next    = y_ball + 10'd1;
    assign lives_dec = lives - 2'd1;

    // 11-bit compare so paddle positions near 1023 cannot wrap past zero.
    always_comb begin
        ball_w = {1'b0, x_ball};
        pad_lo = {1'b0, x_paddle};
        pad_hi = pad_lo + PAD_WIDTH;
        caught = (ball_w >= pad_lo) && (ball_w < pad_hi);
    end

    assign hit   = (st == CHECK) && caught;
    assign miss  = (st == CHECK) && !caught;
    assign state = st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            x_ball <= '0;
            y_ball <= '0;
            score  <= '0;
            lives  <= '0;
            run    <= 1'b0;
        end else begin
            case (st)
                IDLE, OVER: begin
                    if (start) begin
                        score <= '0;
                        lives <= LIVES_INIT;
                        st    <= SPAWN;
                        run   <= 1'b1;
                    end
                end
                SPAWN: begin
                    x_ball <= spawn_x;
                    y_ball <= '0;
                    st     <= PLAY;
                end
                PLAY: begin
                    if (tick) begin
                        y_ball <= y_next;
                        if (y_next == FLOOR_ROW) begin
                            st <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (caught) begin
                        if (score != SCORE_MAX) begin
                            score <= score + 8'd1;
                        end
                        st <= SPAWN;
                    end else begin
                        lives <= lives_dec;
                        if (lives_dec == 2'd0) begin
                            st  <= OVER;
                            run <= 1'b0;
                        end else begin
                            st <= SPAWN;
                        end
                    end
                end
                default: begin
                    st  <= IDLE;
                    run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomised bench for game_ctrl against a score/lives/ball reference model.
module tb_game_ctrl;

    localparam int PW  = 64;
    localparam int FY  = 440;
    localparam int SL  = 3;
    localparam int FY2 = 4;

    logic       clk = 1'b0;
    logic       reset, start, tick, start2, tick2;
    logic [9:0] x_paddle, x_paddle2;
    logic [9:0] x_ball, y_ball, x_ball2, y_ball2;
    logic [7:0] score, score2;
    logic [1:0] lives, lives2;
    logic       run, hit, miss, run2, hit2, miss2;
    logic [2:0] state, state2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] m_lfsr;
    int         m_state, m_score, m_lives;

    always #5 clk = ~clk;

    game_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .x_paddle(x_paddle),
        .x_ball(x_ball), .y_ball(y_ball), .score(score), .lives(lives),
        .run(run), .hit(hit), .miss(miss), .state(state)
    );

    game_ctrl #(.PADDLE_W(PW), .FLOOR_Y(FY2), .START_LIVES(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .tick(tick2), .x_paddle(x_paddle2),
        .x_ball(x_ball2), .y_ball(y_ball2), .score(score2), .lives(lives2),
        .run(run2), .hit(hit2), .miss(miss2), .state(state2)
    );

    // Reference sequence for x^10+x^7+1 from seed 0x2A5.
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 10'h2A5;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    function automatic logic exp_run(input int s);
        return (s >= 1) && (s <= 3);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input bit hold);
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        m_state = 1; m_score = 0; m_lives = SL;
        n_tests++;
        if (state !== 3'd1 || score !== 8'd0 || lives !== 2'(SL) || run !== 1'b1) begin
            n_fail++;
            $display("FAIL start_spawn: state=%0d score=%0d lives=%0d run=%b, want 1/0/%0d/1",
                     state, score, lives, run, SL);
        end
    endtask

    // mode picks the paddle: 0 catch, 1 miss, 2 random, 3 catch edge, 4 miss edge, 5 far right
    task automatic play_ball(input int mode, input int noise);
        int   xb, xp, ticks, guard, nxt;
        logic bad, c;
        xb = int'({1'b0, m_lfsr[8:0]});
        step();
        n_tests++;
        if (state !== 3'd2 || x_ball !== 10'(xb) || y_ball !== 10'd0 || run !== 1'b1) begin
            n_fail++;
            $display("FAIL play_entry: state=%0d x=%0d y=%0d run=%b, want 2/%0d/0/1",
                     state, x_ball, y_ball, run, xb);
        end
        ticks = 0; guard = 0; bad = 1'b0;
        while (ticks < FY && guard < 4 * FY) begin
            guard++;
            tick = ($urandom_range(0, 7) != 0);
            if (noise == 1) start = 1'($urandom_range(0, 1));
            else if (noise == 2) start = 1'b1;
            if (tick) ticks++;
            step();
            tick = 1'b0;
            if (ticks < FY && (state !== 3'd2 || y_ball !== 10'(ticks) || x_ball !== 10'(xb)))
                bad = 1'b1;
        end
        start = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL play_track: ball did not follow ticks (last state=%0d y=%0d), want state 2, y=ticks", state, y_ball);
        end
        n_tests++;
        if (state !== 3'd3 || y_ball !== 10'(FY) || x_ball !== 10'(xb)) begin
            n_fail++;
            $display("FAIL reach_check: state=%0d x=%0d y=%0d, want 3/%0d/%0d", state, x_ball, y_ball, xb, FY);
        end
        case (mode)
            0:       xp = (xb >= 10) ? xb - 10 : 0;
            1:       xp = xb + 1;
            2:       xp = int'($urandom_range(0, 1023));
            3:       xp = (xb >= 63) ? xb - 63 : 0;
            4:       xp = (xb >= 64) ? xb - 64 : xb + 1;
            default: xp = 1000;
        endcase
        x_paddle = 10'(xp);
        #1;
        c = (xb >= xp) && (xb < xp + PW);
        n_tests++;
        if (hit !== c || miss !== !c) begin
            n_fail++;
            $display("FAIL check_pulse: x=%0d paddle=%0d hit=%b miss=%b, want hit=%b miss=%b",
                     xb, xp, hit, miss, c, !c);
        end
        if (c) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            nxt = 1;
        end else begin
            m_lives = m_lives - 1;
            nxt = (m_lives == 0) ? 4 : 1;
        end
        step();
        m_state = nxt;
        n_tests++;
        if (state !== 3'(nxt) || score !== 8'(m_score) || lives !== 2'(m_lives) ||
            hit !== 1'b0 || miss !== 1'b0 || run !== exp_run(nxt)) begin
            n_fail++;
            $display("FAIL after_check: state=%0d score=%0d lives=%0d hit=%b miss=%b run=%b, want %0d/%0d/%0d/0/0/%b",
                     state, score, lives, hit, miss, run, nxt, m_score, m_lives, exp_run(nxt));
        end
    endtask

    task automatic ensure_spawn();
        if (m_state != 1) start_game(1'b0);
    endtask

    task automatic test_reset();
        logic bad;
        reset = 1'b1; start = 1'b0; tick = 1'b0; x_paddle = '0;
        start2 = 1'b0; tick2 = 1'b0; x_paddle2 = '0;
        repeat (3) step();
        n_tests++;
        if ({state, x_ball, y_ball, score, lives, run, hit, miss} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d x=%0d y=%0d score=%0d lives=%0d run=%b hit=%b miss=%b, want all 0",
                     state, x_ball, y_ball, score, lives, run, hit, miss);
        end
        n_tests++;
        if (dut.u_lfsr.q !== 10'h2A5) begin
            n_fail++;
            $display("FAIL reset_lfsr: got %h, want 2a5", dut.u_lfsr.q);
        end
        reset = 1'b0;
        m_state = 0; m_score = 0; m_lives = 0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick = 1'(i % 2);
            step();
            if ({state, x_ball, y_ball, score, lives, run, hit, miss} !== '0) bad = 1'b1;
        end
        tick = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL idle_hold: state=%0d y=%0d, want idle with all outputs 0", state, y_ball);
        end
        n_tests++;
        if (dut.u_lfsr.q !== m_lfsr || dut.u_lfsr.q === 10'd0) begin
            n_fail++;
            $display("FAIL lfsr_track: got %h, want %h", dut.u_lfsr.q, m_lfsr);
        end
    endtask

    task automatic test_catch();
        start_game(1'b0);
        play_ball(0, 0);
    endtask

    task automatic test_miss_to_over();
        for (int i = 0; i < 3; i++) play_ball(1, 0);
        n_tests++;
        if (state !== 3'd4 || lives !== 2'd0 || run !== 1'b0) begin
            n_fail++;
            $display("FAIL over_entry: state=%0d lives=%0d run=%b, want 4/0/0", state, lives, run);
        end
    endtask

    task automatic test_over_hold();
        logic [9:0] hx, hy;
        logic [7:0] hs;
        logic       bad;
        hx = x_ball; hy = y_ball; hs = score; bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick = 1'($urandom_range(0, 1));
            step();
            if (state !== 3'd4 || x_ball !== hx || y_ball !== hy || score !== hs || run !== 1'b0)
                bad = 1'b1;
        end
        tick = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL over_hold: state=%0d x=%0d y=%0d score=%0d, want 4/%0d/%0d/%0d",
                     state, x_ball, y_ball, score, hx, hy, hs);
        end
    endtask

    task automatic test_start_held();
        start_game(1'b1);
        play_ball(2, 2);
    endtask

    task automatic test_boundaries();
        ensure_spawn(); play_ball(3, 1);
        ensure_spawn(); play_ball(4, 1);
        ensure_spawn(); play_ball(5, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            ensure_spawn();
            play_ball(int'($urandom_range(0, 5)), 1);
        end
    endtask

    task automatic test_midgame_reset();
        int guard;
        ensure_spawn();
        tick = 1'b1;
        guard = 0;
        while (state !== 3'd3 && guard < FY + 10) begin
            step();
            guard++;
        end
        tick = 1'b0;
        x_paddle = x_ball + 10'd1;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({state, x_ball, y_ball, score, lives, run, hit, miss} !== '0 || guard >= FY + 10) begin
            n_fail++;
            $display("FAIL midgame_reset: state=%0d x=%0d y=%0d lives=%0d hit=%b miss=%b guard=%0d, want all 0",
                     state, x_ball, y_ball, lives, hit, miss, guard);
        end
        step();
        reset = 1'b0;
        m_state = 0; m_score = 0; m_lives = 0;
    endtask

    task automatic test_saturation();
        int   exp_s, guard, xb2, xp2;
        logic bad, c;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        tick2 = 1'b1;
        exp_s = 0; bad = 1'b0;
        for (int b = 0; b < 256; b++) begin
            guard = 0;
            while (state2 !== 3'd3 && guard < 20) begin
                step();
                guard++;
            end
            if (guard >= 20) bad = 1'b1;
            xb2 = int'(x_ball2);
            xp2 = (xb2 >= 5) ? xb2 - 5 : 0;
            x_paddle2 = 10'(xp2);
            #1;
            c = (xb2 >= xp2) && (xb2 < xp2 + PW);
            if (b == 255) begin
                n_tests++;
                if (hit2 !== c || miss2 !== !c) begin
                    n_fail++;
                    $display("FAIL sat_hit: hit=%b miss=%b, want hit=%b miss=%b", hit2, miss2, c, !c);
                end
            end else if (hit2 !== c || miss2 !== !c) begin
                bad = 1'b1;
            end
            if (c) exp_s = (exp_s < 255) ? exp_s + 1 : 255;
            step();
            if (b == 254) begin
                n_tests++;
                if (score2 !== 8'd255) begin
                    n_fail++;
                    $display("FAIL sat_reach: score=%0d, want 255", score2);
                end
            end else if (b == 255) begin
                n_tests++;
                if (score2 !== 8'd255 || state2 !== 3'd1) begin
                    n_fail++;
                    $display("FAIL sat_hold: score=%0d state=%0d, want 255/1", score2, state2);
                end
            end else if (score2 !== 8'(exp_s)) begin
                bad = 1'b1;
            end
        end
        tick2 = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL sat_progress: score=%0d state=%0d, want steady catches up to 255", score2, state2);
        end
    endtask

    initial begin
        test_reset();
        test_catch();
        test_miss_to_over();
        test_over_hold();
        test_start_held();
        test_boundaries();
        test_random();
        test_midgame_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
